// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 16-state TMS-driven FSM, an instruction register and decode,
// a 1-bit BYPASS register and the TDO mux that sequences the device-ID and user data registers.
module tap_controller #(
  parameter int unsigned              IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0]      IDCODE_OP = {{(IR_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [IR_WIDTH-1:0]      USER_OP   = {{(IR_WIDTH-2){1'b0}}, 2'b10},
  parameter logic [IR_WIDTH-1:0]      BYPASS_OP = {IR_WIDTH{1'b1}}
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo_id,
  input  logic                dr_tdo_user,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir,
  output logic                sel_id,
  output logic                sel_user,
  output logic                sel_bypass,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                clock_dr,
  output logic                tlr
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  // The two LSBs captured into the IR are fixed at 01 so a scan chain can be located.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_e          state_r;
  tap_state_e          state_next_s;
  logic [IR_WIDTH-1:0] ir_r;
  logic [IR_WIDTH-1:0] ir_shift_r;
  logic                bypass_r;
  logic                sel_id_s;
  logic                sel_user_s;
  logic                sel_bypass_s;
  logic                tdo_s;

  // FSM state, instruction, IR shift and BYPASS registers.
  always_ff @(posedge tck) begin
    if (!trst) begin
      state_r    <= TLR;
      ir_r       <= IDCODE_OP;
      ir_shift_r <= {IR_WIDTH{1'b0}};
      bypass_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == TLR) begin
        ir_r <= IDCODE_OP;
      end else if (state_r == UPD_IR) begin
        ir_r <= ir_shift_r;
      end
      if (state_r == CAP_IR) begin
        ir_shift_r <= IR_CAPTURE;
      end else if (state_r == SH_IR) begin
        ir_shift_r <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
      end
      if (sel_bypass_s && (state_r == CAP_DR)) begin
        bypass_r <= 1'b0;
      end else if (sel_bypass_s && (state_r == SH_DR)) begin
        bypass_r <= tdi;
      end
    end
  end

  // TMS-driven next-state logic; DR and IR columns mirror each other.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TLR:     state_next_s = tms ? TLR    : RTI;
      RTI:     state_next_s = tms ? SEL_DR : RTI;
      SEL_DR:  state_next_s = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next_s = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next_s = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next_s = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_next_s = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_next_s = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next_s = tms ? SEL_DR : RTI;
      SEL_IR:  state_next_s = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next_s = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next_s = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next_s = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_next_s = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_next_s = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next_s = tms ? SEL_DR : RTI;
      default: state_next_s = TLR;
    endcase
  end

  // Instruction decode and TDO mux; undefined opcodes fall through to BYPASS.
  always_comb begin
    sel_id_s     = 1'b0;
    sel_user_s   = 1'b0;
    sel_bypass_s = 1'b0;
    tdo_s        = 1'b0;
    case (ir_r)
      IDCODE_OP: sel_id_s     = 1'b1;
      USER_OP:   sel_user_s   = 1'b1;
      BYPASS_OP: sel_bypass_s = 1'b1;
      default:   sel_bypass_s = 1'b1;
    endcase
    case (state_r)
      SH_IR: tdo_s = ir_shift_r[0];
      SH_DR: begin
        if (sel_id_s) begin
          tdo_s = dr_tdo_id;
        end else if (sel_user_s) begin
          tdo_s = dr_tdo_user;
        end else begin
          tdo_s = bypass_r;
        end
      end
      default: tdo_s = 1'b0;
    endcase
  end

  assign state      = state_r;
  assign ir         = ir_r;
  assign sel_id     = sel_id_s;
  assign sel_user   = sel_user_s;
  assign sel_bypass = sel_bypass_s;
  assign tdo        = tdo_s;
  assign tdo_en     = (state_r == SH_DR) || (state_r == SH_IR);
  assign capture_dr = (state_r == CAP_DR);
  assign shift_dr   = (state_r == SH_DR);
  assign update_dr  = (state_r == UPD_DR);
  assign clock_dr   = (state_r == CAP_DR) || (state_r == SH_DR);
  assign tlr        = (state_r == TLR);

endmodule
